// File: rtl/isa_secuenciador_if.sv
// Instruction handshake and datapath bus of the sequencer.
// The sequencer is the slave; the instruction source and datapath form the master.
interface isa_secuenciador_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int OP_W   = 3,
    parameter int CNT_W  = 16
);
    logic              instr_valid;
    logic              instr_ready;
    logic [19:0]       instr;
    logic [ADDR_W-1:0] br_dl1;
    logic [ADDR_W-1:0] br_dl2;
    logic [ADDR_W-1:0] br_de;
    logic [DATA_W-1:0] br_dato;
    logic              br_we;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_res;
    logic [ADDR_W-1:0] ram_dir;
    logic [DATA_W-1:0] ram_datos;
    logic              ram_we;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  instr_count;

    modport master (
        output instr_valid, instr, alu_res,
        input  instr_ready, br_dl1, br_dl2, br_de, br_dato, br_we,
        input  alu_op, ram_dir, ram_datos, ram_we, busy, done, instr_count
    );

    modport slave (
        input  instr_valid, instr, alu_res,
        output instr_ready, br_dl1, br_dl2, br_de, br_dato, br_we,
        output alu_op, ram_dir, ram_datos, ram_we, busy, done, instr_count
    );
endinterface

// File: rtl/isa_secuenciador.sv
// Multi-cycle control FSM for the Banco/ALU/RAM datapath.
// One 20-bit instruction per 5 cycles: READ, EXEC, MEM, WB, DONE.
module isa_secuenciador #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int OP_W   = 3,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    isa_secuenciador_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE,
        READ,
        EXEC,
        MEM,
        WB,
        DONE
    } state_t;

    state_t            state;
    logic [19:0]       ir_q;
    logic [DATA_W-1:0] res_q;
    logic              ready_q;
    logic              busy_q;
    logic              ram_we_q;
    logic              br_we_q;
    logic              done_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              accept;

    assign accept = bus.instr_valid & ready_q;

    // Fields come only from the latched instruction so they hold for the whole run.
    assign bus.br_dl1      = ir_q[19:15];
    assign bus.br_dl2      = ir_q[14:10];
    assign bus.alu_op      = ir_q[8:6];
    assign bus.br_de       = ir_q[5:1];
    assign bus.ram_dir     = ir_q[5:1];
    assign bus.br_dato     = res_q;
    assign bus.ram_datos   = res_q;
    assign bus.br_we       = br_we_q;
    assign bus.ram_we      = ram_we_q;
    assign bus.instr_ready = ready_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.instr_count = cnt_q;

    // Sequencer: strobes are registered one-cycle pulses set on entry to their state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ir_q     <= '0;
            res_q    <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            ram_we_q <= 1'b0;
            br_we_q  <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            ram_we_q <= 1'b0;
            br_we_q  <= 1'b0;
            done_q   <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state   <= READ;
                        ir_q    <= bus.instr;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end else begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                READ: begin
                    state <= EXEC;
                end
                EXEC: begin
                    state    <= MEM;
                    res_q    <= bus.alu_res;
                    ram_we_q <= ir_q[0];
                end
                MEM: begin
                    state   <= WB;
                    br_we_q <= ir_q[9];
                end
                WB: begin
                    state   <= DONE;
                    done_q  <= 1'b1;
                    ready_q <= 1'b1;
                    cnt_q   <= cnt_q + CNT_W'(1);
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
